red_secuencial_der_izq: RTL and testbench
=========================================

Name: red_secuencial_der_izq

Overview:
- Bit-serial, clocked version of the right-to-left iterative comparison network.
- Accepts two N-bit operands through a valid/ready handshake and captures them.
- Processes one bit pair per clock, LSB to MSB, carrying a single state bit p. This is the time-domain unrolling of the initial/typical/final cells.
- Presents the result Zout with a valid/ready handshake to the downstream consumer. Used where area matters more than latency; feeds the same consumers as the combinational network.

Parameters:
- N, 3, operand width in bits; legal range N >= 2.
- IW, $clog2(N), width of the internal bit index (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents A, B.
- in_ready  output  1  block can accept operands; high only in IDLE.
- A  input  N  operand A, unsigned, sampled on the accept edge only.
- B  input  N  operand B, unsigned, sampled on the accept edge only.
- out_valid  output  1  Zout is valid; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- Zout  output  1  1 iff A > B (unsigned); 0 for A == B and A < B.
- busy  output  1  high in SHIFT.

Behaviour:
- Cell function, decided:
  - Initial cell: p0 = A0 & ~B0.
  - Typical and final cells: p' = (Ai & ~Bi) | (~(Ai ^ Bi) & p).
  - The final cell's p' is Z.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Outputs: in_ready=1, out_valid=0, busy=0, Zout=0.
  - Internal: p=0, idx=0; operand shift registers cleared.
  - Takes effect immediately regardless of clk, including mid-SHIFT or in DONE. In-flight operands and any pending result are discarded with no output pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On a clk edge with in_valid=1: capture A and B into internal registers, set idx=0 and p=0, go to SHIFT.
  - With in_valid=0: stay in IDLE.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge evaluates the bit pair at idx with the current p, writes p, and increments idx.
  - At idx==0 the initial-cell equation is used; it is equivalent to the typical cell with p=0.
  - On the edge where idx==N-1: the final result is written to Zout, idx returns to 0, and the state goes to DONE.
  - Exactly N clock edges are spent in SHIFT.
- DONE:
  - out_valid=1; Zout is held stable.
  - On an edge with out_ready=1: go to IDLE, out_valid drops.
  - With out_ready=0: hold indefinitely; Zout and out_valid must not change.
- Latency: operands accepted at edge t; out_valid is high after edge t+N. The earliest result handshake is at edge t+N+1, and the next operand can be accepted at edge t+N+2.
- Throughput: one comparison per N+2 cycles minimum. IDLE and DONE each cost one cycle; there is no combinational ready-through path.
- in_valid, A and B are ignored outside IDLE. Changes on A or B after the accept edge have no effect on the result.
- out_ready is ignored outside DONE. out_ready held high permanently is legal.
- Zout retains its last value in IDLE and SHIFT and is only meaningful while out_valid=1. Zout is updated only on the final SHIFT edge.
- idx never exceeds N-1; no wrap beyond N-1 is permitted.
- Fully synchronous except for the reset. No latches; all state is in flops reset by rst_n.

Test Plan:
- N=3, A=3'b010, B=3'b000, out_ready=1 → in_ready low for 3 SHIFT cycles, out_valid high after the 3rd edge, Zout=1, back to IDLE on the next edge.
- N=3, A=B=3'b101 → Zout=0. Then A=3'b011, B=3'b100 → Zout=0 (the MSB overrides the lower bits). Then A=3'b100, B=3'b011 → Zout=1.
- Backpressure: A=3'b110, B=3'b101, out_ready=0 for 5 cycles after out_valid → out_valid and Zout=1 held for all 5 cycles, in_ready stays 0. Raise out_ready → single handshake, then IDLE.
- Input during operation: A=3'b001, B=3'b000 accepted; during SHIFT drive in_valid=1 with A=3'b000, B=3'b111 → ignored; result Zout=1; the second operand pair is only accepted after returning to IDLE.
- Reset mid-operation: assert rst_n=0 asynchronously (between clock edges) on the 2nd SHIFT cycle → outputs immediately in_ready=1, out_valid=0, busy=0, Zout=0. After release, a new comparison A=3'b111, B=3'b110 → Zout=1 with full N-cycle latency.
- N=8: 1000 random operand pairs with random in_valid/out_ready gaps → every Zout equals (A > B). out_valid rises exactly N edges after each accept; no result is lost or duplicated.

Source files
------------

// File: rtl/red_secuencial_der_izq.sv
// Bit-serial unsigned comparator: Zout = (A > B), evaluated LSB to MSB
// one bit per clock with a single carried state bit p.
module red_secuencial_der_izq #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         Zout,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [IW-1:0] LAST = IW'(N-1);

  state_e          state_q;
  logic [N-1:0]    a_q, b_q;
  logic [IW-1:0]   idx_q;
  logic            p_q, zout_q;
  logic            p_d;

  // Bit 0 of the shift registers is always the pair at idx; p_q is cleared on
  // accept, so the first step reduces to the initial-cell equation.
  always_comb begin
    p_d = (a_q[0] & ~b_q[0]) | (~(a_q[0] ^ b_q[0]) & p_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      p_q     <= 1'b0;
      zout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            idx_q   <= '0;
            p_q     <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          p_q <= p_d;
          if (idx_q == LAST) begin
            zout_q  <= p_d;
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign Zout      = zout_q;

endmodule

// File: tb/tb_red_secuencial_der_izq.sv
// Directed bench for the bit-serial comparator: N=3 handshake/backpressure/
// reset scenarios, then N=8 randomized operands against A > B.
module tb_red_secuencial_der_izq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid3 = 0, out_ready3 = 0;
  logic [2:0] A3 = 0, B3 = 0;
  logic       in_ready3, out_valid3, zout3, busy3;

  logic       in_valid8 = 0, out_ready8 = 0;
  logic [7:0] A8 = 0, B8 = 0;
  logic       in_ready8, out_valid8, zout8, busy8;

  int errors = 0;
  int checks = 0;

  red_secuencial_der_izq #(.N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .A(A3), .B(B3), .out_valid(out_valid3), .out_ready(out_ready3),
    .Zout(zout3), .busy(busy3));

  red_secuencial_der_izq #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A8), .B(B8), .out_valid(out_valid8), .out_ready(out_ready8),
    .Zout(zout8), .busy(busy8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept3(input logic [2:0] a, input logic [2:0] b);
    check("accept3_in_ready", in_ready3, 1);
    in_valid3 = 1; A3 = a; B3 = b;
    tick();
    in_valid3 = 0;
    check("accept3_busy", busy3, 1);
    check("accept3_in_ready_low", in_ready3, 0);
  endtask

  task automatic finish3(input logic exp);
    repeat (2) begin
      tick();
      check("shift3_busy", busy3, 1);
      check("shift3_no_valid", out_valid3, 0);
    end
    tick();
    check("done3_valid", out_valid3, 1);
    check("done3_zout", zout3, exp);
    check("done3_in_ready", in_ready3, 0);
  endtask

  task automatic handshake3();
    out_ready3 = 1;
    tick();
    check("hs3_valid_drop", out_valid3, 0);
    check("hs3_idle", in_ready3, 1);
  endtask

  initial begin
    #2;
    check("rst_in_ready", in_ready3, 1);
    check("rst_out_valid", out_valid3, 0);
    check("rst_busy", busy3, 0);
    check("rst_zout", zout3, 0);
    check("rst8_in_ready", in_ready8, 1);
    #10 rst_n = 1;
    tick();

    // basic: 010 > 000
    out_ready3 = 1;
    accept3(3'b010, 3'b000);
    finish3(1'b1);
    handshake3();

    accept3(3'b101, 3'b101); finish3(1'b0); handshake3();
    accept3(3'b011, 3'b100); finish3(1'b0); handshake3();
    accept3(3'b100, 3'b011); finish3(1'b1); handshake3();

    // backpressure
    out_ready3 = 0;
    accept3(3'b110, 3'b101);
    finish3(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_hold", out_valid3, 1);
      check("bp_zout_hold", zout3, 1);
      check("bp_in_ready", in_ready3, 0);
    end
    handshake3();

    // operands presented during SHIFT are ignored until IDLE
    accept3(3'b001, 3'b000);
    in_valid3 = 1; A3 = 3'b000; B3 = 3'b111;
    finish3(1'b1);
    handshake3();
    tick();
    in_valid3 = 0;
    check("second_accept_busy", busy3, 1);
    finish3(1'b0);
    handshake3();

    // set Zout=1 so the asynchronous reset visibly clears it
    accept3(3'b010, 3'b001); finish3(1'b1); handshake3();
    accept3(3'b011, 3'b000);
    tick();
    check("rst_mid_busy_before", busy3, 1);
    #2 rst_n = 0;
    #1;
    check("arst_in_ready", in_ready3, 1);
    check("arst_out_valid", out_valid3, 0);
    check("arst_busy", busy3, 0);
    check("arst_zout", zout3, 0);
    #2 rst_n = 1;
    tick();
    check("arst_still_idle", in_ready3, 1);
    accept3(3'b111, 3'b110); finish3(1'b1); handshake3();

    // N=8 random with gaps
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      int k;
      a = 8'($urandom); b = 8'($urandom);
      if (i == 0) begin a = 8'hFF; b = 8'hFF; end
      if (i == 1) begin a = 8'h80; b = 8'h7F; end
      out_ready8 = 0;
      repeat ($urandom_range(0, 3)) tick();
      check("r8_in_ready", in_ready8, 1);
      in_valid8 = 1; A8 = a; B8 = b;
      tick();
      k = 0;
      while (k < 20) begin
        in_valid8 = 1'($urandom); A8 = 8'($urandom); B8 = 8'($urandom);
        tick();
        k++;
        if (out_valid8) break;
      end
      in_valid8 = 0;
      check("r8_latency", k, 8);
      check("r8_zout", zout8, (a > b) ? 1 : 0);
      repeat ($urandom_range(0, 3)) begin
        tick();
        check("r8_hold", out_valid8, 1);
      end
      out_ready8 = 1;
      tick();
      check("r8_valid_drop", out_valid8, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
